// File: rtl/stack_arbiter.sv
// Two-requester push/pop sequencer for the return-address stack.
// Define ARB_RR_EN for round-robin ties; otherwise requester 1 wins.
module stack_arbiter #(
   parameter int STK_WIDTH = 32,
   parameter int PTR_WIDTH = 6
) (
   input  logic                 CLK,
   input  logic                 RST,
   input  logic                 REQ0_VALID,
   output logic                 REQ0_READY,
   input  logic                 REQ0_OP,
   input  logic [STK_WIDTH-1:0] REQ0_DATA,
   input  logic                 REQ1_VALID,
   output logic                 REQ1_READY,
   input  logic                 REQ1_OP,
   input  logic [STK_WIDTH-1:0] REQ1_DATA,
   output logic                 RSP_VALID,
   input  logic                 RSP_READY,
   output logic                 RSP_ID,
   output logic [STK_WIDTH-1:0] RSP_DATA,
   output logic                 RSP_ERR,
   output logic                 STK_PUSH,
   output logic                 STK_POP,
   output logic [STK_WIDTH-1:0] STK_DIN,
   input  logic [STK_WIDTH-1:0] STK_DOUT,
   output logic [PTR_WIDTH:0]   COUNT,
   output logic                 FULL,
   output logic                 EMPTY
);

   localparam logic [PTR_WIDTH:0] DEPTH = (PTR_WIDTH+1)'(2**PTR_WIDTH);

   typedef enum logic [1:0] {IDLE, EXEC, CAPTURE, RESP} state_t;

   state_t               state;
   logic                 op;
   logic                 grant1;
   logic                 hs;
   logic                 sel_op;
   logic                 err_now;
   logic [STK_WIDTH-1:0] sel_data;
`ifdef ARB_RR_EN
   logic                 last;
`endif

   assign FULL  = (COUNT == DEPTH);
   assign EMPTY = (COUNT == '0);

   // Ties go to whichever requester was not served last.
   always_comb begin
`ifdef ARB_RR_EN
      grant1 = REQ1_VALID & (~REQ0_VALID | ~last);
`else
      grant1 = REQ1_VALID;
`endif
      hs       = ~RST & (state == IDLE) & (REQ0_VALID | REQ1_VALID);
      sel_op   = grant1 ? REQ1_OP : REQ0_OP;
      sel_data = grant1 ? REQ1_DATA : REQ0_DATA;
      err_now  = sel_op ? FULL : EMPTY;
   end

   assign REQ0_READY = hs & ~grant1;
   assign REQ1_READY = hs & grant1;

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state     <= IDLE;
         op        <= 1'b0;
         COUNT     <= '0;
         STK_PUSH  <= 1'b0;
         STK_POP   <= 1'b0;
         STK_DIN   <= '0;
         RSP_VALID <= 1'b0;
         RSP_ID    <= 1'b0;
         RSP_DATA  <= '0;
         RSP_ERR   <= 1'b0;
`ifdef ARB_RR_EN
         last      <= 1'b1;
`endif
      end else begin
         unique case (state)
            IDLE: begin
               if (hs) begin
                  RSP_ID   <= grant1;
                  op       <= sel_op;
                  STK_DIN  <= sel_data;
                  RSP_DATA <= '0;
                  RSP_ERR  <= err_now;
`ifdef ARB_RR_EN
                  last     <= grant1;
`endif
                  if (err_now) begin
                     RSP_VALID <= 1'b1;
                     state     <= RESP;
                  end else begin
                     STK_PUSH <= sel_op;
                     STK_POP  <= ~sel_op;
                     state    <= EXEC;
                  end
               end
            end
            EXEC: begin
               STK_PUSH <= 1'b0;
               STK_POP  <= 1'b0;
               if (op) begin
                  COUNT     <= COUNT + 1'b1;
                  RSP_VALID <= 1'b1;
                  state     <= RESP;
               end else begin
                  COUNT <= COUNT - 1'b1;
                  state <= CAPTURE;
               end
            end
            CAPTURE: begin
               RSP_DATA  <= STK_DOUT;
               RSP_VALID <= 1'b1;
               state     <= RESP;
            end
            RESP: begin
               if (RSP_READY) begin
                  RSP_VALID <= 1'b0;
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_stack_arbiter.sv
// Bench for stack_arbiter: vector table, LIFO queue model with random
// traffic, and hand sequences for arbitration, backpressure and reset.
module tb_stack_arbiter;

   localparam int W = 32;
   localparam int P = 6;
   localparam int DEPTH = 64;

   logic         clk = 0;
   logic         rst = 1;
   logic         r0_valid = 0, r0_op = 0;
   logic         r1_valid = 0, r1_op = 0;
   logic [W-1:0] r0_data = 0, r1_data = 0;
   logic         r0_ready, r1_ready;
   logic         rsp_valid, rsp_ready = 1, rsp_id, rsp_err;
   logic [W-1:0] rsp_data;
   logic         stk_push, stk_pop;
   logic [W-1:0] stk_din;
   logic [W-1:0] stk_dout;
   logic [P:0]   count;
   logic         full, empty;

   int checks = 0;
   int failures = 0;
   int push_seen = 0;
   int pop_seen = 0;

   stack_arbiter #(.STK_WIDTH(W), .PTR_WIDTH(P)) dut (
      .CLK(clk), .RST(rst),
      .REQ0_VALID(r0_valid), .REQ0_READY(r0_ready),
      .REQ0_OP(r0_op), .REQ0_DATA(r0_data),
      .REQ1_VALID(r1_valid), .REQ1_READY(r1_ready),
      .REQ1_OP(r1_op), .REQ1_DATA(r1_data),
      .RSP_VALID(rsp_valid), .RSP_READY(rsp_ready),
      .RSP_ID(rsp_id), .RSP_DATA(rsp_data), .RSP_ERR(rsp_err),
      .STK_PUSH(stk_push), .STK_POP(stk_pop),
      .STK_DIN(stk_din), .STK_DOUT(stk_dout),
      .COUNT(count), .FULL(full), .EMPTY(empty)
   );

   always #5 clk = ~clk;

   // Physical stack: data appears on stk_dout the cycle after a pop.
   logic [W-1:0] mem [DEPTH];
   int           sp;
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         sp       <= 0;
         stk_dout <= '0;
      end else if (stk_push) begin
         if (sp < DEPTH) mem[sp] <= stk_din;
         sp <= sp + 1;
      end else if (stk_pop) begin
         if (sp > 0) stk_dout <= mem[sp-1];
         sp <= sp - 1;
      end
   end

   task automatic chk(input string name, input logic [63:0] act,
                      input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (stk_push) push_seen++;
      if (stk_pop) pop_seen++;
      if (stk_push || stk_pop)
         chk("strobe_excl", {stk_push, stk_pop} == 2'b11, 0);
   end

   task automatic drive(input int who, input bit v, input bit op,
                        input logic [W-1:0] d);
      if (who == 0) begin
         r0_valid = v; r0_op = op; r0_data = d;
      end else begin
         r1_valid = v; r1_op = op; r1_data = d;
      end
   endtask

   // One full transaction with RSP_READY high; checks latency and fields.
   task automatic xact(input int who, input bit op, input logic [W-1:0] d,
                       input bit e_err, input logic [W-1:0] e_data,
                       input int e_cnt, input string tag);
      int  lat, ps0, pp0, e_lat;
      bit  got;
      @(negedge clk);
      drive(who, 1, op, d);
      rsp_ready = 1;
      #1;
      got = 0;
      for (int i = 0; i < 20; i++) begin
         if ((who == 0) ? r0_ready : r1_ready) begin
            got = 1;
            break;
         end
         @(negedge clk); #1;
      end
      chk({tag, ".grant"}, got, 1);
      ps0 = push_seen;
      pp0 = pop_seen;
      if (got) begin
         @(posedge clk);
         @(negedge clk);
      end
      drive(who, 0, op, d);
      if (!got) return;
      lat = 1;
      while (!rsp_valid && lat < 10) begin
         @(negedge clk);
         lat++;
      end
      e_lat = e_err ? 1 : (op ? 2 : 3);
      chk({tag, ".lat"}, lat, e_lat);
      chk({tag, ".id"}, rsp_id, who);
      chk({tag, ".err"}, rsp_err, e_err);
      chk({tag, ".data"}, rsp_data, e_data);
      @(posedge clk);
      @(negedge clk);
      chk({tag, ".count"}, count, e_cnt);
      chk({tag, ".npush"}, push_seen - ps0, (op && !e_err) ? 1 : 0);
      chk({tag, ".npop"}, pop_seen - pp0, (!op && !e_err) ? 1 : 0);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1;
      repeat (2) @(negedge clk);
      rst = 0;
   endtask

   typedef struct {
      int           who;
      bit           op;
      logic [W-1:0] data;
      bit           err;
      logic [W-1:0] rdata;
      int           cnt;
   } vec_t;

   vec_t vt [10];
   logic [W-1:0] model [$];
   logic exp_g [4];

   initial begin
      vt[0] = '{0, 1, 32'hDEADBEEF, 0, 32'h0, 1};
      vt[1] = '{1, 1, 32'h11, 0, 32'h0, 2};
      vt[2] = '{0, 1, 32'h22, 0, 32'h0, 3};
      vt[3] = '{1, 0, 32'h0, 0, 32'h22, 2};
      vt[4] = '{0, 0, 32'h0, 0, 32'h11, 1};
      vt[5] = '{0, 0, 32'h0, 0, 32'hDEADBEEF, 0};
      vt[6] = '{1, 0, 32'h0, 1, 32'h0, 0};
      vt[7] = '{1, 1, 32'h5A, 0, 32'h0, 1};
      vt[8] = '{0, 0, 32'h0, 0, 32'h5A, 0};
      vt[9] = '{0, 0, 32'h0, 1, 32'h0, 0};

      repeat (3) @(negedge clk);
      chk("rst.count", count, 0);
      chk("rst.empty", empty, 1);
      chk("rst.full", full, 0);
      chk("rst.rsp_valid", rsp_valid, 0);
      chk("rst.strobe", {stk_push, stk_pop}, 0);
      chk("rst.din", stk_din, 0);
      chk("rst.rsp", {rsp_id, rsp_err, rsp_data}, 0);
      r0_valid = 1;
      #1;
      chk("rst.ready", {r0_ready, r1_ready}, 0);
      r0_valid = 0;
      rst = 0;

      for (int i = 0; i < 10; i++)
         xact(vt[i].who, vt[i].op, vt[i].data, vt[i].err,
              vt[i].rdata, vt[i].cnt, $sformatf("vec%0d", i));
      chk("vec.empty", empty, 1);

      for (int i = 0; i < DEPTH; i++) begin
         logic [W-1:0] d;
         d = $urandom;
         model.push_back(d);
         xact(i % 2, 1, d, 0, 0, model.size(), "fill");
      end
      chk("fill.full", full, 1);
      xact(0, 1, 32'hBAD, 1, 0, DEPTH, "ovf");
      chk("ovf.full", full, 1);

      for (int i = 0; i < 120; i++) begin
         bit           op, err;
         int           who;
         logic [W-1:0] d, e;
         op  = $urandom_range(0, 99) < ((i < 60) ? 30 : 70);
         who = $urandom_range(0, 1);
         d   = $urandom;
         e   = 0;
         err = op ? (model.size() == DEPTH) : (model.size() == 0);
         if (!err) begin
            if (op) model.push_back(d);
            else e = model.pop_back();
         end
         xact(who, op, d, err, e, model.size(), $sformatf("rnd%0d", i));
      end

      do_reset();
`ifdef ARB_RR_EN
      exp_g = '{0, 1, 0, 1};
`else
      exp_g = '{1, 1, 1, 1};
`endif
      begin
         int n, cyc;
         @(negedge clk);
         drive(0, 1, 1, 32'hA0);
         drive(1, 1, 1, 32'hB1);
         rsp_ready = 1;
         n = 0;
         cyc = 0;
         while (n < 4 && cyc < 60) begin
            #1;
            if (r0_ready || r1_ready) begin
               chk("arb.one_hot", r0_ready & r1_ready, 0);
               chk($sformatf("arb.grant%0d", n), r1_ready, exp_g[n]);
               n++;
            end
            @(negedge clk);
            cyc++;
         end
         chk("arb.grants", n, 4);
         r1_valid = 0;
         got_r0: begin
            bit g;
            g = 0;
            for (int i = 0; i < 20; i++) begin
               #1;
               if (r0_ready || r1_ready) begin
                  g = 1;
                  break;
               end
               @(negedge clk);
            end
            chk("arb.drop1", {g, r0_ready, r1_ready}, 3'b110);
         end
         @(posedge clk);
         @(negedge clk);
         r0_valid = 0;
         repeat (6) @(negedge clk);
         chk("arb.count", count, 5);
      end

      do_reset();
      xact(0, 1, 32'h77, 0, 0, 1, "bp.push");
      begin
         int k;
         @(negedge clk);
         drive(0, 1, 0, 0);
         rsp_ready = 0;
         #1;
         for (k = 0; k < 20 && !r0_ready; k++) begin
            @(negedge clk); #1;
         end
         chk("bp.grant", r0_ready, 1);
         @(posedge clk);
         @(negedge clk);
         r0_valid = 0;
         drive(1, 1, 1, 32'h99);
         for (k = 0; k < 10 && !rsp_valid; k++) @(negedge clk);
         for (int c = 0; c < 5; c++) begin
            chk($sformatf("bp.hold%0d", c),
                {rsp_valid, rsp_id, rsp_err, rsp_data},
                {1'b1, 1'b0, 1'b0, 32'h77});
            chk($sformatf("bp.noready%0d", c), {r0_ready, r1_ready}, 0);
            @(negedge clk);
         end
         rsp_ready = 1;
         @(posedge clk);
         @(negedge clk);
         #1;
         chk("bp.idle", {rsp_valid, r1_ready}, 2'b01);
         @(posedge clk);
         @(negedge clk);
         r1_valid = 0;
         for (k = 0; k < 10 && !rsp_valid; k++) @(negedge clk);
         chk("bp.rsp2", {rsp_valid, rsp_id, rsp_err, rsp_data},
             {1'b1, 1'b1, 1'b0, 32'h0});
         @(posedge clk);
         @(negedge clk);
         chk("bp.count", count, 1);
      end

      do_reset();
      begin
         int k;
         @(negedge clk);
         drive(0, 1, 1, 32'hAB);
         #1;
         for (k = 0; k < 20 && !r0_ready; k++) begin
            @(negedge clk); #1;
         end
         @(posedge clk);
         @(negedge clk);
         r0_valid = 0;
         chk("mid.strobe", {stk_push, stk_din}, {1'b1, 32'hAB});
         #2 rst = 1;
         #1;
         chk("mid.async", stk_push, 0);
         @(negedge clk);
         rst = 0;
         chk("mid.count", count, 0);
         chk("mid.empty", {empty, rsp_valid}, 2'b10);
      end
      xact(0, 1, 32'h1234, 0, 0, 1, "post_rst");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

endmodule
